// File: rtl/priority_dec.sv
// Index FIFO feeding a one-hot grant generator: each queued index becomes a
// HOLD-cycle one-hot grant, with one idle cycle between back-to-back grants.
module priority_dec #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HOLD  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [2:0] in,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic [3:0] fifo_count
);

  localparam int unsigned PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t      state;
  logic [2:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [3:0]  hold_cnt;
  logic        push;
  logic        pop;
  logic [2:0]  head;

  assign in_ready = (fifo_count != 4'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state != GRANT) && en && (fifo_count != 4'd0);
  assign head     = mem[rd_ptr];
  assign busy     = (fifo_count != 4'd0) || (state != IDLE);

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 4'd0;
    end else begin
      if (push) wr_ptr <= PW'(wr_ptr + PW'(1));
      if (pop)  rd_ptr <= PW'(rd_ptr + PW'(1));
      case ({push, pop})
        2'b10:   fifo_count <= 4'(fifo_count + 4'd1);
        2'b01:   fifo_count <= 4'(fifo_count - 4'd1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Grant FSM; out and out_valid are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out       <= 8'h00;
      out_valid <= 1'b0;
      hold_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (pop) begin
            out       <= 8'(8'd1 << head);
            out_valid <= 1'b1;
            hold_cnt  <= 4'(HOLD - 1);
            state     <= GRANT;
          end else begin
            out       <= 8'h00;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        GRANT: begin
          if (hold_cnt == 4'd0) begin
            out       <= 8'h00;
            out_valid <= 1'b0;
            // With nothing queued, GAP would only fall through to IDLE.
            state     <= ((fifo_count != 4'd0) || push) ? GAP : IDLE;
          end else begin
            hold_cnt <= 4'(hold_cnt - 4'd1);
          end
        end
        default: begin
          out       <= 8'h00;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_dec.sv
// Directed bench for priority_dec: HOLD=2 instance for the main scenarios and
// a HOLD=1 instance for the full index sweep.
module tb_priority_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, in_valid;
  logic [2:0] in;
  logic       in_ready, out_valid, busy;
  logic [7:0] out;
  logic [3:0] fifo_count;

  logic       en_b, in_valid_b;
  logic [2:0] in_b;
  logic       in_ready_b, out_valid_b, busy_b;
  logic [7:0] out_b;
  logic [3:0] fifo_count_b;

  int n_chk  = 0;
  int n_fail = 0;
  int max_cnt;

  logic [7:0] b2b_exp  [9]  = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h00, 8'h08, 8'h08, 8'h00};
  logic [7:0] full_exp [12] = '{8'h04, 8'h04, 8'h00, 8'h10, 8'h10, 8'h00,
                                8'h10, 8'h10, 8'h00, 8'h02, 8'h02, 8'h00};
  logic [2:0] full_in  [4]  = '{3'd2, 3'd4, 3'd4, 3'd1};
  logic [7:0] onehot   [8]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  always #5 clk = ~clk;

  priority_dec #(.DEPTH(4), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .busy(busy),
    .fifo_count(fifo_count)
  );

  priority_dec #(.DEPTH(4), .HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .in_valid(in_valid_b), .in(in_b),
    .in_ready(in_ready_b), .out(out_b), .out_valid(out_valid_b), .busy(busy_b),
    .fifo_count(fifo_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in = 3'd0;
    en_b = 1'b0; in_valid_b = 1'b0; in_b = 3'd0;
    step(); step();
    chk("rst_out", 32'(out), 32'h00);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(fifo_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst = 1'b0;
    step();

    // Single grant of index 5
    en = 1'b1; in_valid = 1'b1; in = 3'd5;
    step();
    in_valid = 1'b0;
    chk("single_cnt_k", 32'(fifo_count), 32'd1);
    chk("single_busy_k", 32'(busy), 32'd1);
    step();
    chk("single_out_k1", 32'(out), 32'h20);
    chk("single_vld_k1", 32'(out_valid), 32'd1);
    chk("single_cnt_k1", 32'(fifo_count), 32'd0);
    step();
    chk("single_out_k2", 32'(out), 32'h20);
    step();
    chk("single_out_k3", 32'(out), 32'h00);
    chk("single_busy_k3", 32'(busy), 32'd0);

    // Back-to-back pushes 0,7,3
    max_cnt = 0;
    in_valid = 1'b1; in = 3'd0;
    step();
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 2);
      in = (i == 0) ? 3'd7 : 3'd3;
      step();
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      chk($sformatf("b2b_out_%0d", i), 32'(out), 32'(b2b_exp[i]));
      chk($sformatf("b2b_vld_%0d", i), 32'(out_valid), 32'(b2b_exp[i] != 8'h00));
    end
    chk("b2b_maxcnt", 32'(max_cnt), 32'd2);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // Fill with en low, offer a fifth index, then drain in order
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in = full_in[i];
      step();
    end
    chk("full_cnt", 32'(fifo_count), 32'd4);
    chk("full_rdy", 32'(in_ready), 32'd0);
    in = 3'd6;
    step(); step();
    chk("full_cnt_hold", 32'(fifo_count), 32'd4);
    chk("full_out_idle", 32'(out), 32'h00);
    in_valid = 1'b0; en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("full_out_%0d", i), 32'(out), 32'(full_exp[i]));
    end
    chk("full_cnt_end", 32'(fifo_count), 32'd0);
    chk("full_busy_end", 32'(busy), 32'd0);

    // en dropped during the first grant cycle
    in_valid = 1'b1; in = 3'd3;
    step();
    in = 3'd5;
    step();
    en = 1'b0; in_valid = 1'b0;
    chk("endrop_out_g1", 32'(out), 32'h08);
    step();
    chk("endrop_out_g2", 32'(out), 32'h08);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("endrop_out_off%0d", i), 32'(out), 32'h00);
      chk($sformatf("endrop_cnt_off%0d", i), 32'(fifo_count), 32'd1);
    end
    en = 1'b1;
    step();
    chk("endrop_out_resume", 32'(out), 32'h20);
    chk("endrop_cnt_resume", 32'(fifo_count), 32'd0);
    step();
    chk("endrop_out_resume2", 32'(out), 32'h20);
    step();
    chk("endrop_out_after", 32'(out), 32'h00);

    // Reset during GRANT with two indices queued
    in_valid = 1'b1; in = 3'd1;
    step();
    in = 3'd2;
    step();
    in = 3'd3;
    step();
    in_valid = 1'b0;
    chk("midrst_pre_out", 32'(out), 32'h02);
    chk("midrst_pre_cnt", 32'(fifo_count), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out", 32'(out), 32'h00);
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(fifo_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("midrst_quiet_%0d", i), 32'(out), 32'h00);
    end

    // HOLD=1 sweep of all indices, one push every other cycle
    en_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid_b = 1'b1; in_b = 3'(i);
      step();
      in_valid_b = 1'b0;
      chk($sformatf("sweep_gap_%0d", i), 32'(out_b), 32'h00);
      step();
      chk($sformatf("sweep_out_%0d", i), 32'(out_b), 32'(onehot[i]));
    end
    step();
    chk("sweep_out_end", 32'(out_b), 32'h00);
    chk("sweep_busy_end", 32'(busy_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
